// File: rtl/sub64_pipe_if.sv
// Operand/result stream bundle for the pipelined subtractor.
// The master drives operands and result-ready; the slave is the pipeline.
interface sub64_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, A, B, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, A, B, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/sub64_pipe.sv
// Pipelined A - B - bin, one 16-bit slice per stage, computed as A + ~B + ~bin.
// Valid/ready stream with a combinational ready chain; bubbles collapse under stall.
module sub64_pipe #(
    parameter int WIDTH  = 64,
    parameter int NSTAGE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sub64_pipe_if.slave bus
);
    localparam int SW = 16;

    logic [NSTAGE:1]   v_q;
    logic [NSTAGE:1]   adv;
    logic [NSTAGE:1]   v_src;
    logic [WIDTH-1:0]  r_q   [1:NSTAGE];
    logic [WIDTH-1:0]  r_src [1:NSTAGE];
    logic [WIDTH-1:0]  r_d   [1:NSTAGE];
    // Stage NSTAGE consumes the last operand slice, so it keeps no operands or carry.
    logic [WIDTH-1:0]  a_q   [1:NSTAGE-1];
    logic [WIDTH-1:0]  b_q   [1:NSTAGE-1];
    logic [WIDTH-1:0]  a_src [1:NSTAGE];
    logic [WIDTH-1:0]  b_src [1:NSTAGE];
    logic [NSTAGE-1:1] c_q;
    logic [NSTAGE-1:1] am_q;
    logic [NSTAGE-1:1] bm_q;
    logic [NSTAGE:1]   c_src;
    logic [NSTAGE:1]   c_d;
    logic [NSTAGE:1]   am_src;
    logic [NSTAGE:1]   bm_src;
    logic              bout_q, zero_q, ovf_q;
    logic              bout_d, zero_d, ovf_d;

    always_comb begin
        logic          full;
        logic [SW:0]   sum;
        full = 1'b1;
        sum  = '0;
        // A stage stalls only if it and every stage after it are occupied.
        for (int k = 1; k <= NSTAGE; k++) begin
            full = 1'b1;
            for (int j = k; j <= NSTAGE; j++) begin
                full = full & v_q[j];
            end
            adv[k] = !full || bus.out_ready;
        end

        v_src[1]  = bus.in_valid && adv[1];
        a_src[1]  = bus.A;
        b_src[1]  = bus.B;
        r_src[1]  = '0;
        c_src[1]  = ~bus.bin;
        am_src[1] = bus.A[WIDTH-1];
        bm_src[1] = bus.B[WIDTH-1];
        for (int k = 2; k <= NSTAGE; k++) begin
            v_src[k]  = v_q[k-1];
            a_src[k]  = a_q[k-1];
            b_src[k]  = b_q[k-1];
            r_src[k]  = r_q[k-1];
            c_src[k]  = c_q[k-1];
            am_src[k] = am_q[k-1];
            bm_src[k] = bm_q[k-1];
        end

        for (int k = 1; k <= NSTAGE; k++) begin
            sum = {1'b0, a_src[k][SW*k-1 -: SW]} + {1'b0, ~b_src[k][SW*k-1 -: SW]}
                + {{SW{1'b0}}, c_src[k]};
            r_d[k] = r_src[k];
            r_d[k][SW*k-1 -: SW] = sum[SW-1:0];
            c_d[k] = sum[SW];
        end

        bout_d = ~c_d[NSTAGE];
        zero_d = (r_d[NSTAGE] == '0);
        ovf_d  = (am_src[NSTAGE] ^ bm_src[NSTAGE]) & (am_src[NSTAGE] ^ r_d[NSTAGE][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            am_q   <= '0;
            bm_q   <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int k = 1; k <= NSTAGE; k++) begin
                r_q[k] <= '0;
            end
            for (int k = 1; k < NSTAGE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= NSTAGE; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_src[k];
                    r_q[k] <= r_d[k];
                end
            end
            for (int k = 1; k < NSTAGE; k++) begin
                if (adv[k]) begin
                    a_q[k]  <= a_src[k];
                    b_q[k]  <= b_src[k];
                    c_q[k]  <= c_d[k];
                    am_q[k] <= am_src[k];
                    bm_q[k] <= bm_src[k];
                end
            end
            // Flags load with the final slice so they always describe the presented diff.
            if (adv[NSTAGE]) begin
                bout_q <= bout_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = adv[1];
    assign bus.out_valid = v_q[NSTAGE];
    assign bus.diff      = r_q[NSTAGE];
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sub64_pipe.sv
// Bench for sub64_pipe: directed corner vectors, backpressure, bubbles,
// random valid/ready traffic against an arithmetic reference, and async reset.
module tb_sub64_pipe;
    localparam int W = 64;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sub64_pipe_if #(.WIDTH(W)) bus ();

    sub64_pipe #(.WIDTH(W), .NSTAGE(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         z;
        logic         o;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    res_t q[$];

    // Reference: wide unsigned and signed differences, no slicing.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W+1:0] u;
        logic [W+1:0] s;
        res_t         r;
        u   = {2'b00, a} - {2'b00, b} - (W+2)'(bi);
        s   = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b} - (W+2)'(bi);
        r.d = u[W-1:0];
        r.b = u[W+1];
        r.z = (u[W-1:0] == '0);
        r.o = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
        return r;
    endfunction

    function automatic res_t dut_out();
        return {bus.diff, bus.bout, bus.zero, bus.ovf};
    endfunction

    function automatic logic [W-1:0] rand64();
        case ($urandom % 6)
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic ordy);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.bin       = bi;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 64'h55, 64'h3, 1'b1, 1'b0);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if (dut_out() !== res_t'('0)) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", dut_out());
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6];
        logic [W-1:0] tb [6];
        logic         tbi[6];
        res_t         texp[6];
        ta[0] = 64'h0000_0000_0001_0000; tb[0] = 64'h1; tbi[0] = 1'b0;
        texp[0] = {64'h0000_0000_0000_FFFF, 3'b000};
        ta[1] = 64'h0; tb[1] = 64'h1; tbi[1] = 1'b0;
        texp[1] = {64'hFFFF_FFFF_FFFF_FFFF, 3'b100};
        ta[2] = 64'h0; tb[2] = 64'h0; tbi[2] = 1'b1;
        texp[2] = {64'hFFFF_FFFF_FFFF_FFFF, 3'b100};
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h0; tbi[3] = 1'b1;
        texp[3] = {64'h7FFF_FFFF_FFFF_FFFF, 3'b001};
        ta[4] = 64'h1234_5678_9ABC_DEF0; tb[4] = 64'h1234_5678_9ABC_DEF0; tbi[4] = 1'b0;
        texp[4] = {64'h0, 3'b010};
        ta[5] = 64'h5; tb[5] = 64'h7; tbi[5] = 1'b1;
        texp[5] = {64'hFFFF_FFFF_FFFF_FFFD, 3'b100};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ta[i], tb[i], tbi[i], 1'b1);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
            end
            for (int c = 0; c < N; c++) begin
                drive(1'b0, '0, '0, 1'b0, 1'b1);
                total++;
                if (bus.out_valid !== (c == N-1)) begin
                    bad++; $display("FAIL dir%0d_latency c%0d: out_valid got %b want %b",
                                    i, c, bus.out_valid, (c == N-1));
                end
            end
            total++;
            if (dut_out() !== texp[i]) begin
                bad++; $display("FAIL dir%0d_result: got %h want %h", i, dut_out(), texp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   popped = 0;
        int   c = 0;
        logic ordy, iv, exp_rdy;
        logic prev_hold = 1'b0;
        logic saw_full = 1'b0;
        res_t prev = '0;
        while ((sent < 8 || q.size() > 0) && c < 200) begin
            iv   = (sent < 8);
            ordy = !(c >= 5 && c <= 9);
            drive(iv, 64'(sent + 100), 64'(sent), 1'b0, ordy);
            exp_rdy = (q.size() < N) || ordy;
            total++;
            if (bus.in_ready !== exp_rdy) begin
                bad++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy);
            end
            if (!bus.in_ready) saw_full = 1'b1;
            if (prev_hold) begin
                total++;
                if (bus.out_valid !== 1'b1 || dut_out() !== prev) begin
                    bad++; $display("FAIL bp_stable c%0d: got %b/%h want 1/%h",
                                    c, bus.out_valid, dut_out(), prev);
                end
            end
            if (bus.out_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL bp_spurious c%0d: got %h want no beat", c, dut_out());
                end else begin
                    if (dut_out() !== q[0]) begin
                        bad++; $display("FAIL bp_data c%0d: got %h want %h", c, dut_out(), q[0]);
                    end
                    if (ordy) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            prev_hold = (bus.out_valid === 1'b1) && !ordy;
            prev      = dut_out();
            if (iv && bus.in_ready === 1'b1) begin
                q.push_back(model(64'(sent + 100), 64'(sent), 1'b0));
                sent++;
            end
            c++;
        end
        total++;
        if (popped != 8 || q.size() != 0) begin
            bad++; $display("FAIL bp_count: got %0d emitted (%0d pending) want 8", popped, q.size());
        end
        total++;
        if (!saw_full) begin
            bad++; $display("FAIL bp_full: got in_ready never low want low while 4 held");
        end
        q.delete();
    endtask

    task automatic test_bubbles();
        logic         hist [0:31];
        logic         iv, expv, bi;
        logic [W-1:0] a, b;
        for (int c = 0; c < 24; c++) begin
            iv = (c < 16) && (c % 2 == 0);
            a  = rand64();
            b  = rand64();
            bi = 1'($urandom % 2);
            drive(iv, a, b, bi, 1'b1);
            expv = (c >= N) ? hist[c-N] : 1'b0;
            total++;
            if (bus.out_valid !== expv) begin
                bad++; $display("FAIL bub_valid c%0d: got %b want %b", c, bus.out_valid, expv);
            end
            if (bus.out_valid === 1'b1 && q.size() > 0) begin
                total++;
                if (dut_out() !== q[0]) begin
                    bad++; $display("FAIL bub_data c%0d: got %h want %h", c, dut_out(), q[0]);
                end
                void'(q.pop_front());
            end
            hist[c] = iv && (bus.in_ready === 1'b1);
            if (hist[c]) q.push_back(model(a, b, bi));
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL bub_drain: got %0d pending want 0", q.size());
        end
        q.delete();
    endtask

    task automatic test_random();
        int           c = 0;
        logic         iv, ordy, bi, exp_rdy;
        logic [W-1:0] a, b;
        while ((c < 400 || q.size() > 0) && c < 460) begin
            iv   = (c < 400) && ($urandom % 4 != 0);
            ordy = (c >= 400) || ($urandom % 3 != 0);
            a    = rand64();
            b    = rand64();
            bi   = 1'($urandom % 2);
            drive(iv, a, b, bi, ordy);
            exp_rdy = (q.size() < N) || ordy;
            total++;
            if (bus.in_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, bus.in_ready, exp_rdy);
            end
            if (bus.out_valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious c%0d: got %h want no beat", c, dut_out());
                end else begin
                    if (dut_out() !== q[0]) begin
                        bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, dut_out(), q[0]);
                    end
                    if (ordy) void'(q.pop_front());
                end
            end
            if (iv && bus.in_ready === 1'b1) q.push_back(model(a, b, bi));
            c++;
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rnd_drain: got %0d pending want 0", q.size());
        end
        q.delete();
    endtask

    task automatic test_async_reset();
        int   waitc = 0;
        res_t e;
        drive(1'b1, 64'h0, 64'h5, 1'b0, 1'b1);
        drive(1'b1, 64'h9, 64'h2, 1'b0, 1'b1);
        drive(1'b1, 64'h7, 64'h7, 1'b1, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        while (bus.out_valid !== 1'b1 && waitc < 8) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            waitc++;
        end
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL ar_pre_valid: got %b want 1", bus.out_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL ar_out_valid: got %b want 0", bus.out_valid);
        end
        total++;
        if (dut_out() !== res_t'('0)) begin
            bad++; $display("FAIL ar_outputs: got %h want 0", dut_out());
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL ar_in_ready: got %b want 1", bus.in_ready);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL ar_quiet c%0d: got %b want 0", c, bus.out_valid);
            end
        end
        e = model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0002, 1'b1);
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_0002, 1'b1, 1'b1);
        for (int c = 0; c < N; c++) drive(1'b0, '0, '0, 1'b0, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || dut_out() !== e) begin
            bad++; $display("FAIL ar_after: got %b/%h want 1/%h", bus.out_valid, dut_out(), e);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_bubbles();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sub64_pipe.md
Name: sub64_pipe

Overview:
- Pipelined 64-bit subtractor: computes DIFF = A - B - bin. It is the inverse-direction companion to the team's 64-bit carry-lookahead adder.
- Each stage resolves one 16-bit slice. The borrow is carried forward stage to stage, in the same 16-bit slicing the adder uses for its lookahead blocks.
- Sits in the datapath wherever operands arrive as a valid/ready stream and results must be backpressurable.
- Throughput is one operation per clock. Latency is NSTAGE cycles.

Parameters:
- WIDTH, 64, operand/result width; must equal NSTAGE*16.
- NSTAGE, 4, number of pipeline stages, one 16-bit slice each.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- A, input, WIDTH, minuend.
- B, input, WIDTH, subtrahend.
- bin, input, 1, borrow in (1 = subtract an extra 1).
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, downstream accepts the result.
- diff, output, WIDTH, A - B - bin mod 2^WIDTH.
- bout, output, 1, borrow out of MSB (1 = unsigned A < B + bin).
- zero, output, 1, diff == 0.
- ovf, output, 1, signed overflow.

Behaviour:
- Reset is asynchronous, active-low, on rst_n only; no other reset input.
- While rst_n=0:
  - All stage valid bits clear; all stage data registers clear.
  - out_valid=0, diff=0, bout=0, zero=0, ovf=0.
  - in_ready=1 (no stage is holding data).
- Arithmetic: implemented as A + ~B + ~bin.
  - Stage k (k=1..NSTAGE) computes bits [16k-1:16k-16] using the carry from stage k-1. Stage 1 uses carry-in = ~bin.
  - bout = ~carry out of bit WIDTH-1.
- Stage register contents:
  - valid bit.
  - Result slices already computed.
  - Remaining unconsumed A/B slices.
  - Internal carry.
  - A[WIDTH-1] and B[WIDTH-1], retained for ovf.
- Flags are registered with the final stage, so they are coherent with diff:
  - zero = (diff == 0).
  - ovf = (A[63]^B[63]) & (A[63]^diff[63]); valid for either value of bin.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - adv[NSTAGE] = !v[NSTAGE] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[1]. The ready chain is combinational.
  - Stage k loads from stage k-1 when adv[k]. Its valid bit becomes v[k-1] (stage 0 valid = in_valid && in_ready).
  - A stage with adv[k]=0 holds its contents unchanged.
- Output signals: out_valid = v[NSTAGE]; diff/bout/zero/ovf are driven directly from the final stage registers.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSTAGE-1, i.e. NSTAGE cycles of occupancy, when unstalled.
- Full pipeline with out_ready=0:
  - All stages hold and in_ready=0.
  - At most NSTAGE beats are in flight; no loss, duplication or reordering.
- Output stability: while out_valid=1 && out_ready=0, diff/bout/zero/ovf are stable.
- Simultaneous accept and emit in the same cycle is legal; a full pipeline with out_ready=1 sustains 1 beat/cycle.
- Bubbles (in_valid=0) propagate as invalid stages. A bubble collapses when a downstream stage stalls, because a stage with v=0 always advances.
- Reset mid-operation: all in-flight beats are discarded. No output beat appears until new input has been accepted after release and has traversed the pipeline.
- Wrap-around: diff is taken modulo 2^WIDTH; the underflow indication is on bout only.

Test Plan:
- Slice borrow: A=0x0000_0000_0001_0000, B=1, bin=0, out_ready=1 -> after 4 cycles diff=0x0000_0000_0000_FFFF, bout=0, zero=0, ovf=0.
- Full underflow: A=0, B=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Then A=0, B=0, bin=1 -> identical result.
- Signed overflow with bin: A=0x8000_0000_0000_0000, B=0, bin=1 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1. Also A=B=0x1234_5678_9ABC_DEF0, bin=0 -> diff=0, zero=1, bout=0.
- Backpressure: 8 back-to-back beats (A=i+100, B=i) with out_ready=0 on cycles 5-9.
  - in_ready drops once 4 beats are held.
  - All 8 outputs diff=100 emerge in order, none lost or duplicated.
  - Outputs hold stable during the stall.
- Throughput plus bubbles: alternate in_valid 1/0 with out_ready=1 -> alternating out_valid, each result correct, latency 4.
- Async reset: 3 beats in flight, assert rst_n=0 mid-cycle -> out_valid, diff and flags go 0 immediately, in_ready=1. After release with no input, out_valid stays 0 for 10 cycles.
